// File: rtl/hv_fault_mgr.sv
// HV-side fault manager: per-channel mask, debounce filter and sticky latch feeding a
// fault/recovery FSM that gates PWM and drives INTB. Define HV_FAULT_CNT_EN for occurrence counters.
module hv_fault_mgr #(
    parameter int ERR_NUM = 8,
    parameter int FLT_W   = 4,
    parameter int RCV_W   = 8,
    parameter int CNT_W   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_fsm_en,
    input  logic [ERR_NUM-1:0] i_err_raw,
    input  logic [ERR_NUM-1:0] i_err_mask,
    input  logic [ERR_NUM-1:0] i_err_hard,
    input  logic [FLT_W-1:0]   i_flt_len,
    input  logic [RCV_W-1:0]   i_rcv_len,
    input  logic [ERR_NUM-1:0] i_clr,
    output logic [ERR_NUM-1:0] o_err_sticky,
    output logic               o_pwm_allow,
    output logic               o_intb_n,
    output logic [1:0]         o_fault_st
`ifdef HV_FAULT_CNT_EN
    ,
    output logic [ERR_NUM*CNT_W-1:0] o_fault_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2,
        ST_RCV   = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic [ERR_NUM-1:0][FLT_W-1:0]   flt_cnt_q, flt_cnt_d;
    logic [ERR_NUM-1:0]              flt_q, flt_d;
    logic [ERR_NUM-1:0]              sticky_q, sticky_d;
    logic [RCV_W-1:0]                timer_q, timer_d;
    logic                            pwm_allow_q, pwm_allow_d;
    logic                            intb_n_q, intb_n_d;
    logic [ERR_NUM-1:0]              act;
    logic                            hard_act;
    logic                            hard_stk;

    assign act      = i_err_raw & ~i_err_mask;
    assign hard_act = |(flt_q & i_err_hard);
    assign hard_stk = |(sticky_q & i_err_hard);

    // The filter counter saturates at L; a channel only reports once it has seen L+1 active samples.
    always_comb begin
        flt_cnt_d = flt_cnt_q;
        flt_d     = '0;
        for (int i = 0; i < ERR_NUM; i++) begin
            if (!i_fsm_en || !act[i]) begin
                flt_cnt_d[i] = '0;
            end else if (flt_cnt_q[i] >= i_flt_len) begin
                flt_cnt_d[i] = i_flt_len;
            end else begin
                flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
            end
            flt_d[i] = i_fsm_en & act[i] & (flt_cnt_q[i] == i_flt_len);
        end
        sticky_d = (sticky_q & ~(i_clr & ~flt_q)) | flt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        if (!i_fsm_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   if (hard_act) state_d = ST_FAULT;
                ST_FAULT: if (!hard_act && !hard_stk) state_d = ST_RCV;
                ST_RCV: begin
                    if (hard_act) begin
                        state_d = ST_FAULT;
                    end else if (timer_q == i_rcv_len) begin
                        state_d = ST_RUN;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pwm_allow_d = (state_d == ST_RUN);
        intb_n_d    = ~((state_d == ST_FAULT) | (state_d == ST_RCV) | (|sticky_d));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flt_cnt_q   <= '0;
            flt_q       <= '0;
            sticky_q    <= '0;
            timer_q     <= '0;
            pwm_allow_q <= 1'b0;
            intb_n_q    <= 1'b1;
        end else begin
            flt_cnt_q   <= flt_cnt_d;
            flt_q       <= flt_d;
            sticky_q    <= sticky_d;
            timer_q     <= timer_d;
            pwm_allow_q <= pwm_allow_d;
            intb_n_q    <= intb_n_d;
        end
    end

    assign o_err_sticky = sticky_q;
    assign o_pwm_allow  = pwm_allow_q;
    assign o_intb_n     = intb_n_q;
    assign o_fault_st   = state_q;

`ifdef HV_FAULT_CNT_EN
    logic [ERR_NUM-1:0][CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic [ERR_NUM-1:0]            flt_rise;

    // A clear coinciding with a new rising edge leaves the count at one.
    always_comb begin
        flt_rise    = flt_d & ~flt_q;
        fault_cnt_d = fault_cnt_q;
        for (int i = 0; i < ERR_NUM; i++) begin
            if (i_clr[i]) begin
                fault_cnt_d[i] = CNT_W'(flt_rise[i]);
            end else if (flt_rise[i] && !(&fault_cnt_q[i])) begin
                fault_cnt_d[i] = fault_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign o_fault_cnt = fault_cnt_q;
`endif

endmodule

// File: tb/tb_hv_fault_mgr.sv
// Self-checking bench for hv_fault_mgr: directed scenarios plus randomized traffic against a
// cycle-level behavioural model. Occurrence counters are checked when HV_FAULT_CNT_EN is defined.
module tb_hv_fault_mgr;

    localparam int ERR_NUM = 8;
    localparam int FLT_W   = 4;
    localparam int RCV_W   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               fsm_en;
    logic [ERR_NUM-1:0] raw;
    logic [ERR_NUM-1:0] mask;
    logic [ERR_NUM-1:0] hard;
    logic [FLT_W-1:0]   flt_len;
    logic [RCV_W-1:0]   rcv_len;
    logic [ERR_NUM-1:0] clr;
    logic [ERR_NUM-1:0] sticky;
    logic               pwm_allow;
    logic               intb_n;
    logic [1:0]         fault_st;
`ifdef HV_FAULT_CNT_EN
    logic [ERR_NUM*CNT_W-1:0] fault_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model: run lengths of active samples, state as an integer, cycles spent in recovery.
    int                 m_run [ERR_NUM];
    int                 m_cnt [ERR_NUM];
    logic [ERR_NUM-1:0] m_flt;
    logic [ERR_NUM-1:0] m_stk;
    int                 m_st;
    int                 m_rcv_age;
    logic               m_pwm;
    logic               m_intb;

    hv_fault_mgr #(
        .ERR_NUM(ERR_NUM),
        .FLT_W  (FLT_W),
        .RCV_W  (RCV_W),
        .CNT_W  (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_fsm_en    (fsm_en),
        .i_err_raw   (raw),
        .i_err_mask  (mask),
        .i_err_hard  (hard),
        .i_flt_len   (flt_len),
        .i_rcv_len   (rcv_len),
        .i_clr       (clr),
        .o_err_sticky(sticky),
        .o_pwm_allow (pwm_allow),
        .o_intb_n    (intb_n),
        .o_fault_st  (fault_st)
`ifdef HV_FAULT_CNT_EN
        ,
        .o_fault_cnt (fault_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < ERR_NUM; i++) begin
            m_run[i] = 0;
            m_cnt[i] = 0;
        end
        m_flt     = '0;
        m_stk     = '0;
        m_st      = 0;
        m_rcv_age = 0;
        m_pwm     = 1'b0;
        m_intb    = 1'b1;
    endtask

    task automatic modelStep();
        logic [ERR_NUM-1:0] act;
        logic [ERR_NUM-1:0] new_flt;
        logic [ERR_NUM-1:0] new_stk;
        logic               hard_now;
        logic               hard_latched;
        int                 new_st;
        act          = raw & ~mask;
        hard_now     = |(m_flt & hard);
        hard_latched = |(m_stk & hard);
        new_stk      = (m_stk & ~(clr & ~m_flt)) | m_flt;
        for (int i = 0; i < ERR_NUM; i++) begin
            if (fsm_en && act[i]) begin
                new_flt[i] = (m_run[i] >= int'(flt_len));
                m_run[i]   = (m_run[i] < 1000) ? m_run[i] + 1 : 1000;
            end else begin
                new_flt[i] = 1'b0;
                m_run[i]   = 0;
            end
            if (clr[i]) begin
                m_cnt[i] = (new_flt[i] && !m_flt[i]) ? 1 : 0;
            end else if (new_flt[i] && !m_flt[i] && m_cnt[i] < CNT_MAX) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        new_st = m_st;
        if (!fsm_en) begin
            new_st = 0;
        end else if (m_st == 0) begin
            new_st = 1;
        end else if (m_st == 1) begin
            if (hard_now) new_st = 2;
        end else if (m_st == 2) begin
            if (!hard_now && !hard_latched) begin
                new_st    = 3;
                m_rcv_age = 1;
            end
        end else begin
            if (hard_now) begin
                new_st = 2;
            end else if (m_rcv_age == int'(rcv_len) + 1) begin
                new_st = 1;
            end else begin
                m_rcv_age = m_rcv_age + 1;
            end
        end
        m_flt  = new_flt;
        m_stk  = new_stk;
        m_st   = new_st;
        m_pwm  = (new_st == 1);
        m_intb = !((new_st == 2) || (new_st == 3) || (|new_stk));
    endtask

    task automatic checkOutput();
        checkValue("sticky", 32'(sticky), 32'(m_stk));
        checkValue("pwm_allow", 32'(pwm_allow), 32'(m_pwm));
        checkValue("intb_n", 32'(intb_n), 32'(m_intb));
        checkValue("fault_st", 32'(fault_st), 32'(m_st));
`ifdef HV_FAULT_CNT_EN
        for (int i = 0; i < ERR_NUM; i++) begin
            checkValue("fault_cnt", 32'(fault_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
        end
`endif
    endtask

    task automatic applyStimulus(input logic [ERR_NUM-1:0] r, input logic [ERR_NUM-1:0] c);
        @(negedge clk);
        raw = r;
        clr = c;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    initial begin
        logic [ERR_NUM-1:0] r;
        rst_n   = 1'b0;
        fsm_en  = 1'b0;
        raw     = '0;
        mask    = '0;
        hard    = '0;
        flt_len = '0;
        rcv_len = '0;
        clr     = '0;
        modelReset();
        #12;
        checkValue("reset_sticky", 32'(sticky), 32'h0);
        checkValue("reset_pwm", 32'(pwm_allow), 32'h0);
        checkValue("reset_intb", 32'(intb_n), 32'h1);
        checkValue("reset_state", 32'(fault_st), 32'h0);
`ifdef HV_FAULT_CNT_EN
        checkValue("reset_cnt", 32'(fault_cnt), 32'h0);
`endif
        @(negedge clk);
        rst_n   = 1'b1;
        fsm_en  = 1'b1;
        flt_len = 4'd3;
        rcv_len = 8'd5;
        hard    = 8'h04;
        applyStimulus(8'h00, 8'h00);
        checkValue("idle_to_run", 32'(fault_st), 32'h1);

        // Debounce length 3: three samples are not enough, four are.
        repeat (3) applyStimulus(8'h01, 8'h00);
        applyStimulus(8'h00, 8'h00);
        checkValue("t1_short_sticky", 32'(sticky[0]), 32'h0);
        checkValue("t1_short_intb", 32'(intb_n), 32'h1);
        repeat (4) applyStimulus(8'h01, 8'h00);
        checkValue("t1_long_sticky_early", 32'(sticky[0]), 32'h0);
        applyStimulus(8'h00, 8'h00);
        checkValue("t1_long_sticky", 32'(sticky[0]), 32'h1);
        checkValue("t1_long_intb", 32'(intb_n), 32'h0);
        applyStimulus(8'h00, 8'h01);
        checkValue("t1_clear_sticky", 32'(sticky), 32'h0);
        checkValue("t1_clear_intb", 32'(intb_n), 32'h1);

        // Hard fault with L=0, then recovery hold-off of R=5.
        flt_len = 4'd0;
        applyStimulus(8'h04, 8'h00);
        checkValue("t2_run_pwm", 32'(pwm_allow), 32'h1);
        applyStimulus(8'h04, 8'h00);
        checkValue("t2_fault_state", 32'(fault_st), 32'h2);
        checkValue("t2_fault_pwm", 32'(pwm_allow), 32'h0);
        applyStimulus(8'h00, 8'h04);
        applyStimulus(8'h00, 8'h04);
        checkValue("t2_still_fault", 32'(fault_st), 32'h2);
        checkValue("t2_sticky_clr", 32'(sticky[2]), 32'h0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(8'h00, 8'h00);
            checkValue("t2_rcv_state", 32'(fault_st), 32'h3);
            checkValue("t2_rcv_pwm", 32'(pwm_allow), 32'h0);
        end
        applyStimulus(8'h00, 8'h00);
        checkValue("t2_back_run", 32'(fault_st), 32'h1);
        checkValue("t2_back_pwm", 32'(pwm_allow), 32'h1);

        // Masked channel is fully ignored.
        mask = 8'h02;
        repeat (50) applyStimulus(8'h02, 8'h00);
        checkValue("t3_sticky", 32'(sticky), 32'h0);
        checkValue("t3_state", 32'(fault_st), 32'h1);
        checkValue("t3_pwm", 32'(pwm_allow), 32'h1);
        checkValue("t3_intb", 32'(intb_n), 32'h1);
        mask = 8'h00;
        applyStimulus(8'h00, 8'h00);

        // Clear is refused while the filtered error is still active.
        applyStimulus(8'h08, 8'h00);
        applyStimulus(8'h08, 8'h00);
        checkValue("t4_sticky_set", 32'(sticky[3]), 32'h1);
        applyStimulus(8'h08, 8'h08);
        checkValue("t4_clr_blocked", 32'(sticky[3]), 32'h1);
        checkValue("t4_soft_stays_run", 32'(fault_st), 32'h1);
        applyStimulus(8'h00, 8'h00);
        applyStimulus(8'h00, 8'h08);
        checkValue("t4_clr_done", 32'(sticky[3]), 32'h0);
        checkValue("t4_intb", 32'(intb_n), 32'h1);

        // Re-fault during recovery restarts the hold-off; disable forces IDLE.
        applyStimulus(8'h04, 8'h00);
        applyStimulus(8'h04, 8'h00);
        applyStimulus(8'h00, 8'h04);
        applyStimulus(8'h00, 8'h04);
        applyStimulus(8'h00, 8'h00);
        applyStimulus(8'h00, 8'h00);
        applyStimulus(8'h04, 8'h00);
        checkValue("t5_rcv_before_refault", 32'(fault_st), 32'h3);
        applyStimulus(8'h04, 8'h00);
        checkValue("t5_refault", 32'(fault_st), 32'h2);
        applyStimulus(8'h00, 8'h04);
        applyStimulus(8'h00, 8'h04);
        applyStimulus(8'h00, 8'h00);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'h00, 8'h00);
            checkValue("t5_rcv_restart", 32'(fault_st), 32'h3);
        end
        applyStimulus(8'h00, 8'h00);
        checkValue("t5_run_again", 32'(fault_st), 32'h1);
        applyStimulus(8'h04, 8'h00);
        applyStimulus(8'h04, 8'h00);
        fsm_en = 1'b0;
        applyStimulus(8'h04, 8'h00);
        checkValue("t5_disable_state", 32'(fault_st), 32'h0);
        checkValue("t5_disable_pwm", 32'(pwm_allow), 32'h0);
        checkValue("t5_disable_sticky", 32'(sticky[2]), 32'h1);
        fsm_en = 1'b1;
        applyStimulus(8'h00, 8'h04);
        checkValue("t5_sticky_cleared", 32'(sticky), 32'h0);

`ifdef HV_FAULT_CNT_EN
        applyStimulus(8'h00, 8'h01);
        repeat (3) begin
            applyStimulus(8'h01, 8'h00);
            applyStimulus(8'h00, 8'h00);
        end
        checkValue("t6_cnt_three", 32'(fault_cnt[CNT_W-1:0]), 32'd3);
        repeat (17) begin
            applyStimulus(8'h01, 8'h00);
            applyStimulus(8'h00, 8'h00);
        end
        checkValue("t6_cnt_sat", 32'(fault_cnt[CNT_W-1:0]), 32'd15);
        applyStimulus(8'h00, 8'h01);
        checkValue("t6_cnt_clr", 32'(fault_cnt[CNT_W-1:0]), 32'd0);
`endif

        // Randomized traffic; configuration only changes while the manager is disabled.
        r = '0;
        for (int seg = 0; seg < 40; seg++) begin
            fsm_en  = 1'b0;
            flt_len = FLT_W'($urandom_range(0, 3));
            rcv_len = RCV_W'($urandom_range(0, 7));
            mask    = ERR_NUM'($urandom & $urandom);
            hard    = ERR_NUM'($urandom);
            r       = '0;
            applyStimulus(r, ERR_NUM'($urandom));
            fsm_en = 1'b1;
            for (int k = 0; k < 40; k++) begin
                for (int b = 0; b < ERR_NUM; b++) begin
                    if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
                end
                fsm_en = ($urandom_range(0, 59) != 0);
                applyStimulus(r, ERR_NUM'($urandom & $urandom & $urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
